// File: rtl/matrix_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// matrix_write_arbiter_if
// Bundles every matrix writer's request/data lines and the single storage
// manager write port into one interface.
//
// Requester side (packed, requester i owns slice i):
//   req_write_request  [NUM_REQ]        held write request
//   req_matrix_id      [NUM_REQ*3]      target matrix id, slice [3i+:3]
//   req_rows/req_cols  [NUM_REQ*8]      matrix geometry
//   req_name           [NUM_REQ*64]     8 name bytes, byte k = [64i+8k+:8]
//   req_data           [NUM_REQ*DW]     element beat
//   req_data_valid     [NUM_REQ]        element strobe
//   req_write_ready    [NUM_REQ]        port-free indication
//   req_writer_ready   [NUM_REQ]        storage writer_ready, granted bit only
//   req_write_done     [NUM_REQ]        storage write_done, granted bit only
// Storage side:
//   sm_write_request, sm_matrix_id, sm_rows, sm_cols, sm_name, sm_data,
//   sm_data_valid (to storage); sm_write_ready, sm_writer_ready,
//   sm_write_done (from storage, write_done is a 1-cycle pulse).
//
// Handshake: a requester holds write_request until its write_done; data
// beats are accepted on every cycle data_valid is high once writer_ready
// has been seen; write_done ends the transaction.
//
// Modports: slave = the arbiter, master = the writers/storage environment.
// ---------------------------------------------------------------------------
interface matrix_write_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_write_request;
    logic [NUM_REQ*3-1:0]          req_matrix_id;
    logic [NUM_REQ*8-1:0]          req_rows;
    logic [NUM_REQ*8-1:0]          req_cols;
    logic [NUM_REQ*64-1:0]         req_name;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_data_valid;
    logic [NUM_REQ-1:0]            req_write_ready;
    logic [NUM_REQ-1:0]            req_writer_ready;
    logic [NUM_REQ-1:0]            req_write_done;

    logic                          sm_write_request;
    logic [2:0]                    sm_matrix_id;
    logic [7:0]                    sm_rows;
    logic [7:0]                    sm_cols;
    logic [63:0]                   sm_name;
    logic [DATA_WIDTH-1:0]         sm_data;
    logic                          sm_data_valid;
    logic                          sm_write_ready;
    logic                          sm_writer_ready;
    logic                          sm_write_done;

    modport slave (
        input  req_write_request, req_matrix_id, req_rows, req_cols,
               req_name, req_data, req_data_valid,
               sm_write_ready, sm_writer_ready, sm_write_done,
        output req_write_ready, req_writer_ready, req_write_done,
               sm_write_request, sm_matrix_id, sm_rows, sm_cols, sm_name,
               sm_data, sm_data_valid
    );

    modport master (
        output req_write_request, req_matrix_id, req_rows, req_cols,
               req_name, req_data, req_data_valid,
               sm_write_ready, sm_writer_ready, sm_write_done,
        input  req_write_ready, req_writer_ready, req_write_done,
               sm_write_request, sm_matrix_id, sm_rows, sm_cols, sm_name,
               sm_data, sm_data_valid
    );
endinterface

// File: rtl/matrix_write_arbiter.sv
// ---------------------------------------------------------------------------
// matrix_write_arbiter
// Shares the storage-manager write port between NUM_REQ matrix writers.
// Round-robin arbitration; one grant covers a whole write transaction
// (request -> writer_ready -> data beats -> write_done). A watchdog frees a
// grant that never completes, and a requester that withdraws its request
// before writer_ready aborts its grant.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     requester and storage-manager signals
//   grant_valid     high exactly while a grant is active
//   grant_id        index of the granted requester
//   timeout_err     1-cycle pulse in the GRANT cycle the watchdog releases
//   dbg_state       current FSM state (0 IDLE, 1 GRANT, 2 RELEASE)
// ---------------------------------------------------------------------------
module matrix_write_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    matrix_write_arbiter_if.slave      bus,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    output logic [1:0]                 dbg_state
);
    localparam int IDW = $clog2(NUM_REQ);
    // Watchdog disabled still keeps a 1-bit counter so widths stay legal.
    localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST =
        WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [WDW-1:0] WD_MAX = {WDW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [WDW-1:0] wd_cnt;
    logic           wr_seen;     // writer_ready observed during this grant

    logic           pick_valid;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] scan_idx;
    logic           granted_req;
    logic           timeout_hit;
    logic           abort;

    assign dbg_state = state;

    // Round-robin scan starting at rr_ptr; the first set request wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_valid && bus.req_write_request[scan_idx]) begin
                pick_valid = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    assign granted_req = bus.req_write_request[grant_id];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
    // Withdrawal only aborts before the storage side has committed.
    assign abort       = !granted_req && !wr_seen && !bus.sm_writer_ready;
    // Completion beats the watchdog when both land in the same cycle.
    assign timeout_err = (state == ST_GRANT) && timeout_hit && !bus.sm_write_done;

    // Output routing: storage bus is a mux of the granted slice during
    // GRANT only, so RELEASE and IDLE always present an idle bus.
    always_comb begin
        bus.req_write_ready  = '0;
        bus.req_writer_ready = '0;
        bus.req_write_done   = '0;
        bus.sm_write_request = 1'b0;
        bus.sm_matrix_id     = '0;
        bus.sm_rows          = '0;
        bus.sm_cols          = '0;
        bus.sm_name          = '0;
        bus.sm_data          = '0;
        bus.sm_data_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_write_ready = {NUM_REQ{bus.sm_write_ready}};
            end
            ST_GRANT: begin
                bus.req_write_ready[grant_id]  = bus.sm_write_ready;
                bus.req_writer_ready[grant_id] = bus.sm_writer_ready;
                bus.req_write_done[grant_id]   = bus.sm_write_done;
                bus.sm_write_request = granted_req;
                bus.sm_matrix_id     = bus.req_matrix_id[grant_id*3 +: 3];
                bus.sm_rows          = bus.req_rows[grant_id*8 +: 8];
                bus.sm_cols          = bus.req_cols[grant_id*8 +: 8];
                bus.sm_name          = bus.req_name[grant_id*64 +: 64];
                bus.sm_data          = bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
                bus.sm_data_valid    = bus.req_data_valid[grant_id];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
            wr_seen     <= 1'b0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd_cnt  <= '0;
                    wr_seen <= 1'b0;
                    if (bus.sm_write_ready && pick_valid) begin
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (wd_cnt != WD_MAX) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    if (bus.sm_writer_ready) begin
                        wr_seen <= 1'b1;
                    end
                    if (bus.sm_write_done || timeout_hit || abort) begin
                        grant_valid <= 1'b0;
                        state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    rr_ptr  <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    wd_cnt  <= '0;
                    wr_seen <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_matrix_write_arbiter
// Self-checking bench: hand sequences for reset, single write, mid-grant
// request, watchdog, abort and reset mid-beat, then a table of request
// patterns with their expected round-robin winners. Data beats are pushed
// to exp_q when driven and popped when seen on the storage bus.
// ---------------------------------------------------------------------------
module tb_matrix_write_arbiter;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout_err;
    logic [1:0] dbg_state;

    matrix_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    matrix_write_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [2:0]  exp_id[NR];
    logic [7:0]  exp_rows[NR];
    logic [7:0]  exp_cols[NR];
    logic [63:0] exp_name[NR];

    typedef struct {
        logic [2:0] want;   // requests held when the grant is decided
        int         exp_g;  // expected winner
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int r, input logic [2:0] id, input logic [7:0] rows,
                         input logic [7:0] cols);
        logic [63:0] nm;
        nm = {8'h4D, 8'h41, 8'h54, 8'(r), 5'd0, id, rows, cols, 8'h5A};
        bus.req_matrix_id[3*r +: 3] = id;
        bus.req_rows[8*r +: 8]      = rows;
        bus.req_cols[8*r +: 8]      = cols;
        bus.req_name[64*r +: 64]    = nm;
        exp_id[r]   = id;
        exp_rows[r] = rows;
        exp_cols[r] = cols;
        exp_name[r] = nm;
        bus.req_write_request[r] = 1'b1;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (!grant_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant_seen", 64'(grant_valid), 64'(1));
    endtask

    // Runs one full transaction for the expected winner; mid_r >= 0 raises
    // another request while the grant is active.
    task automatic serve(input int exp_g, input int nbeats, input logic [DW-1:0] base,
                         input int exp_lat, input int mid_r);
        int cyc;
        logic [NR-1:0] oh;
        logic [DW-1:0] v;
        oh = '0;
        oh[exp_g] = 1'b1;
        wait_grant(cyc);
        if (exp_lat >= 0) chk("grant_latency", 64'(cyc), 64'(exp_lat));
        chk("grant_id", 64'(grant_id), 64'(exp_g));
        chk("sm_write_request", 64'(bus.sm_write_request), 64'(1));
        chk("sm_matrix_id", 64'(bus.sm_matrix_id), 64'(exp_id[exp_g]));
        chk("sm_rows_cols", 64'({bus.sm_rows, bus.sm_cols}),
            64'({exp_rows[exp_g], exp_cols[exp_g]}));
        chk("sm_name", bus.sm_name, exp_name[exp_g]);
        chk("req_write_ready_grant", 64'(bus.req_write_ready), 64'(oh));
        if (mid_r >= 0) begin
            step();
            raise(mid_r, 3'd5, 8'd1, 8'd1);
        end
        step();
        bus.sm_writer_ready = 1'b1;
        @(negedge clk);
        chk("req_writer_ready", 64'(bus.req_writer_ready), 64'(oh));
        for (int b = 0; b < nbeats; b++) begin
            step();
            bus.sm_writer_ready = 1'b0;
            v = base * DW'(b + 1);
            bus.req_data[DW*exp_g +: DW] = v;
            bus.req_data_valid[exp_g]    = 1'b1;
            exp_q.push_back(v);
            @(negedge clk);
            chk("sm_data_valid", 64'(bus.sm_data_valid), 64'(1));
            if (exp_q.size() > 0) chk("sm_data", 64'(bus.sm_data), 64'(exp_q.pop_front()));
            chk("writer_ready_other", 64'(bus.req_writer_ready), 64'(0));
        end
        step();
        bus.req_data_valid[exp_g] = 1'b0;
        bus.sm_write_done = 1'b1;
        @(negedge clk);
        chk("req_write_done", 64'(bus.req_write_done), 64'(oh));
        chk("no_timeout_on_done", 64'(timeout_err), 64'(0));
        step();
        bus.sm_write_done = 1'b0;
        bus.req_write_request[exp_g] = 1'b0;
        @(negedge clk);
        chk("release_gap", 64'({grant_valid, bus.sm_write_request, bus.sm_data_valid,
                                bus.req_write_ready}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    // ---------------- test sequence ----------------
    initial begin
        int cyc;
        int n;
        int first_to;
        logic seen_dv;
        logic seen_to;

        vecs[0] = '{3'b101, 0};
        vecs[1] = '{3'b100, 2};
        vecs[2] = '{3'b011, 0};
        vecs[3] = '{3'b011, 1};
        vecs[4] = '{3'b111, 2};
        vecs[5] = '{3'b011, 0};
        vecs[6] = '{3'b110, 1};
        vecs[7] = '{3'b100, 2};

        bus.req_write_request = '0;
        bus.req_matrix_id     = '0;
        bus.req_rows          = '0;
        bus.req_cols          = '0;
        bus.req_name          = '0;
        bus.req_data          = '0;
        bus.req_data_valid    = '0;
        bus.sm_write_ready    = 1'b1;
        bus.sm_writer_ready   = 1'b0;
        bus.sm_write_done     = 1'b0;

        // Reset state
        #12;
        chk("rst_grant_valid", 64'(grant_valid), 64'(0));
        chk("rst_sm_bus", 64'({bus.sm_write_request, bus.sm_data_valid, timeout_err}), 64'(0));
        chk("rst_routed", 64'({bus.req_writer_ready, bus.req_write_done}), 64'(0));
        chk("rst_write_ready", 64'(bus.req_write_ready), 64'(3'b111));
        step();
        rst_n = 1'b1;

        // Storage not ready: no grant, write_ready low
        bus.sm_write_ready = 1'b0;
        raise(2, 3'd1, 8'd1, 8'd1);
        repeat (3) @(negedge clk);
        chk("blocked_write_ready", 64'(bus.req_write_ready), 64'(0));
        chk("blocked_no_grant", 64'(grant_valid), 64'(0));
        step();
        bus.req_write_request[2] = 1'b0;
        bus.sm_write_ready = 1'b1;
        #1;
        chk("idle_write_ready", 64'(bus.req_write_ready), 64'(3'b111));

        // Single req1: id 3, 2x2, beats 0x11..0x44
        step();
        raise(1, 3'd3, 8'd2, 8'd2);
        serve(1, 4, 32'h11, 2, -1);

        // req1 raised during req0 grant waits for release
        step();
        raise(0, 3'd2, 8'd3, 8'd4);
        serve(0, 3, 32'h0100_0000 + DW'($urandom_range(1, 255)), 2, 1);
        serve(1, 2, DW'($urandom_range(1, 65535)), 2, -1);

        // Watchdog: storage never gives writer_ready or done
        step();
        raise(0, 3'd6, 8'd8, 8'd8);
        wait_grant(cyc);
        chk("to_grant_id", 64'(grant_id), 64'(0));
        n = 1;
        first_to = 0;
        while (grant_valid && n < 40) begin
            if (timeout_err && first_to == 0) first_to = n;
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", 64'(first_to), 64'(TO));
        chk("timeout_released", 64'({grant_valid, timeout_err}), 64'(0));
        step();
        bus.req_write_request[0] = 1'b0;
        raise(2, 3'd7, 8'd1, 8'd2);
        serve(2, 2, DW'($urandom_range(1, 65535)), 2, -1);

        // Abort before writer_ready; stray strobe from a non-granted writer
        step();
        raise(1, 3'd4, 8'd5, 8'd5);
        bus.req_data[DW*2 +: DW] = 32'hDEAD_BEEF;
        bus.req_data_valid[2] = 1'b1;
        seen_dv = 1'b0;
        seen_to = 1'b0;
        wait_grant(cyc);
        chk("abort_grant_id", 64'(grant_id), 64'(1));
        seen_dv = seen_dv | bus.sm_data_valid;
        step();
        bus.req_write_request[1] = 1'b0;
        @(negedge clk);
        seen_dv = seen_dv | bus.sm_data_valid;
        seen_to = seen_to | timeout_err;
        @(negedge clk);
        chk("abort_released", 64'({grant_valid, dbg_state}), 64'({1'b0, 2'd2}));
        chk("abort_no_data_no_timeout", 64'({seen_dv, seen_to, timeout_err}), 64'(0));
        step();
        bus.req_data_valid[2] = 1'b0;

        // Reset in the middle of data beats
        step();
        raise(0, 3'd1, 8'd2, 8'd3);
        wait_grant(cyc);
        step();
        bus.sm_writer_ready = 1'b1;
        step();
        bus.sm_writer_ready = 1'b0;
        bus.req_data[0 +: DW] = 32'hCAFE_0001;
        bus.req_data_valid[0] = 1'b1;
        exp_q.push_back(32'hCAFE_0001);
        @(negedge clk);
        if (exp_q.size() > 0) chk("pre_reset_beat", 64'(bus.sm_data), 64'(exp_q.pop_front()));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_sm", 64'({bus.sm_write_request, bus.sm_data_valid}), 64'(0));
        chk("mid_reset_data", 64'(bus.sm_data), 64'(0));
        chk("mid_reset_state", 64'({grant_valid, dbg_state, bus.req_writer_ready,
                                    bus.req_write_done}), 64'(0));
        #1;
        bus.req_write_request = '0;
        bus.req_data_valid    = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        raise(2, 3'd2, 8'd4, 8'd4);
        serve(2, 2, DW'($urandom_range(1, 65535)), 2, -1);

        // Table of round-robin patterns, rr_ptr starts at 0 here
        for (int e = 0; e < 8; e++) begin
            step();
            for (int r = 0; r < NR; r++) begin
                if (vecs[e].want[r] && !bus.req_write_request[r])
                    raise(r, 3'(e), 8'(e + 1), 8'(r + 2));
            end
            serve(vecs[e].exp_g, 2, DW'($urandom_range(1, 65535)), 2, -1);
        end

        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
